// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM state encoding,
// frame-bit counts and the integer baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit; truncating division, so the real baud rate is never below nominal.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with registered occupancy count; full and
// empty are decoded from the count register.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a bit-serialising FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    output logic                            txd,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output tx_state_t                       dbg_state
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_buffered: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    // Handshake: a byte transfers on any rising edge where data_valid && data_ready;
    // the producer holds data_in stable until then, and data_ready never depends on data_valid.
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] fifo_dout;

    tx_state_t      state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           bit_end;
`ifdef UART_TX_PARITY_EN
    logic           parity_bit;
`endif

    assign data_ready = !fifo_full;
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign bit_end    = (baud_cnt == CW'(DIV - 1));
    assign dbg_state  = state;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_valid),
        .pop   (fifo_pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // txd is registered from the current state, so the line lags the state by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            busy <= (state != ST_IDLE) || !fifo_empty;

            if (state == ST_IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shift   <= fifo_dout;
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_dout;
`endif
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    txd <= shift[0];
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    txd <= parity_bit;
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at DIV=10; a line decoder on txd pops the expected-byte queue.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS      = 11;
`else
  localparam int NBITS      = 10;
`endif
  localparam int SPACING    = NBITS * DIV + 1;
  localparam int WAIT_MAX   = 30000;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;
  tx_state_t  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic       spacing_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] b);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    data_in = b;
    data_valid = 1'b1;
    while (!acc && budget < 2000) begin
      @(negedge clk);
      acc = data_ready;
      @(posedge clk);
      #1;
      if (acc) exp_q.push_back(b);
      budget++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  logic mon_active = 1'b0;

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 || mon_active) && n < WAIT_MAX) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(n < WAIT_MAX), 32'd1);
  endtask

  // scoreboard monitor: decodes txd frames and compares against exp_q
  int          mon_cnt = 0;
  logic [10:0] bits = '0;
  logic        prev_txd = 1'b1;
  int          last_start = -1;
  logic [7:0]  got;
  logic [7:0]  exp_b;

  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      prev_txd   = 1'b1;
      last_start = -1;
    end else begin
      check("count_bound", 32'(fifo_count <= 5'd16), 32'd1);
      check("ready_vs_count", 32'(data_ready), 32'(fifo_count != 5'd16));
      if (!spacing_en) last_start = -1;
      if (!mon_active) begin
        if (prev_txd && !txd) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          if (last_start >= 0) check("start_spacing", 32'(cyc - last_start), 32'(SPACING));
          last_start = cyc;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_active && (mon_cnt % DIV) == DIV / 2) begin
        bits[mon_cnt / DIV] = txd;
        if (mon_cnt / DIV == NBITS - 1) begin
          mon_active = 1'b0;
          got = bits[8:1];
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[NBITS-1]), 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check("frame_data", 32'(got), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", 32'(bits[9]), 32'(^exp_b));
`endif
          end
        end
      end
      prev_txd = txd;
    end
  end

  // stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(data_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single 0xA5 frame with latency and busy timing
    send(8'hA5);
    data_valid = 1'b0;
    @(posedge clk); #1;
    check("latency_idle_txd", 32'(txd), 32'd1);
    check("busy_rise", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("latency_start_txd", 32'(txd), 32'd0);
    repeat (99) @(posedge clk);
    #1;
    check("stop_txd", 32'(txd), 32'd1);
    check("busy_before_drop", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("busy_drop", 32'(busy), 32'd0);
    check("idle_txd", 32'(txd), 32'd1);
    wait_idle();

    // back-to-back frames with start-to-start spacing
    spacing_en = 1'b1;
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    data_valid = 1'b0;
    wait_idle();
    spacing_en = 1'b0;

    // fill to full, then hold valid while the FSM frees slots
    for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_ready", 32'(data_ready), 32'd0);
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
    check("hold_count", 32'(fifo_count), 32'd16);
    data_valid = 1'b0;
    wait_idle();

    // reset mid-DATA of 0x55 with bytes still queued
    send(8'h55);
    send(8'h11);
    send(8'h22);
    data_valid = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("mid_frame_state", 32'(dbg_state), 32'(ST_DATA));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(data_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h81);
    data_valid = 1'b0;
    wait_idle();

`ifdef UART_TX_PARITY_EN
    spacing_en = 1'b1;
    send(8'h07);
    send(8'h03);
    data_valid = 1'b0;
    wait_idle();
    spacing_en = 1'b0;
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
